// File: rtl/complex_counter_pkg.sv
// Shared constants, mode encoding and Gray/binary conversion helpers for complex_counter.
// Pure definitions: no latency and no flow control.
package complex_counter_pkg;

    localparam int CC_WIDTH = 3;
    localparam int CC_FN_W  = 32;

    typedef logic [CC_FN_W-1:0] cc_word_t;

    typedef enum logic {
        CC_BINARY = 1'b0,
        CC_GRAY   = 1'b1
    } cc_mode_e;

    // The helpers work on a 32-bit container.
    // Only the low 'width' bits are meaningful, and the rest are cleared.
    function automatic cc_word_t cc_mask(input int width);
        cc_word_t m;
        if (width >= CC_FN_W) begin
            m = '1;
        end else begin
            m = (cc_word_t'(1) << width) - cc_word_t'(1);
        end
        return m;
    endfunction

    function automatic cc_word_t bin2gray(input cc_word_t bin, input int width);
        cc_word_t b;
        b = bin & cc_mask(width);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of its own Gray bit and every Gray bit above it.
    function automatic cc_word_t gray2bin(input cc_word_t gray, input int width);
        cc_word_t g;
        cc_word_t b;
        g = gray & cc_mask(width);
        b = g;
        for (int i = 1; i < CC_FN_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_successor.sv
// Combinational next-code generator for a WIDTH-bit reflected Gray counter (2 <= WIDTH <= 32).
// Zero latency, no flow control. The all-ones-binary code wraps to zero.
module gray_successor
    import complex_counter_pkg::*;
#(
    parameter int WIDTH = CC_WIDTH
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] gray_next_o
);

    cc_word_t bin_w;
    cc_word_t bin_inc_w;
    cc_word_t gray_w;

    // The increment is masked before re-encoding.
    // A carry out of the top bit must not leak into the Gray MSB.
    always_comb begin
        bin_w       = gray2bin(cc_word_t'(gray_i), WIDTH);
        bin_inc_w   = (bin_w + cc_word_t'(1)) & cc_mask(WIDTH);
        gray_w      = bin2gray(bin_inc_w, WIDTH);
        gray_next_o = gray_w[WIDTH-1:0];
    end

endmodule

// File: rtl/complex_counter.sv
// Mode-selectable free-running counter (binary or reflected Gray); registered output, 1-cycle latency.
// No backpressure or enable: it advances on every rising edge while out of reset.
module complex_counter
    import complex_counter_pkg::*;
#(
    parameter int WIDTH = CC_WIDTH
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             M,
    output logic [WIDTH-1:0] Count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] gray_next;
    cc_mode_e         mode;

    gray_successor #(
        .WIDTH (WIDTH)
    ) u_gray_successor (
        .gray_i      (count_q),
        .gray_next_o (gray_next)
    );

    // The successor is always taken of the present value.
    // No re-encoding happens when the mode changes.
    always_comb begin
        mode    = cc_mode_e'(M);
        count_d = count_q + WIDTH'(1);
        if (mode == CC_GRAY) begin
            count_d = gray_next;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Count = count_q;

endmodule

// File: tb/tb_complex_counter.sv
// Table-driven and hand-sequenced checks of complex_counter in binary and Gray modes,
// covering mode switches and asynchronous reset.
module tb_complex_counter;

    logic       Clk;
    logic       nReset;
    logic       M;
    logic [2:0] Count;

    int checks;
    int failures;

    typedef struct {
        logic       nrst;
        logic       m;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[$];

    logic [2:0] gray_seq [8];

    complex_counter #(.WIDTH(3)) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .M      (M),
        .Count  (Count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: Count=%b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic nrst, input logic m, input logic [2:0] exp);
        vec_t v;
        v.nrst = nrst;
        v.m    = m;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    initial begin
        logic [2:0] prev;
        logic [2:0] exp_v;

        checks   = 0;
        failures = 0;
        nReset   = 1'b0;
        M        = 1'b0;

        gray_seq[0] = 3'b000; gray_seq[1] = 3'b001; gray_seq[2] = 3'b011; gray_seq[3] = 3'b010;
        gray_seq[4] = 3'b110; gray_seq[5] = 3'b111; gray_seq[6] = 3'b101; gray_seq[7] = 3'b100;

        // A record with nrst=0 asserts reset and checks Count before any clock edge.
        // Any other record drives M and checks Count just after the next rising edge.
        add(1'b0, 1'b0, 3'd0);
        add(1'b1, 1'b0, 3'd1); add(1'b1, 1'b0, 3'd2); add(1'b1, 1'b0, 3'd3);
        add(1'b1, 1'b1, 3'b010); add(1'b1, 1'b1, 3'b110); add(1'b1, 1'b1, 3'b111);
        add(1'b1, 1'b0, 3'b000); add(1'b1, 1'b0, 3'b001);
        add(1'b0, 1'b0, 3'd0);
        add(1'b1, 1'b0, 3'd1);
        add(1'b0, 1'b0, 3'd0);
        for (int i = 1; i <= 8; i++) add(1'b1, 1'b0, 3'(i % 8));
        add(1'b0, 1'b1, 3'd0);
        for (int i = 1; i <= 8; i++) add(1'b1, 1'b1, gray_seq[i % 8]);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge Clk);
            nReset = vecs[i].nrst;
            M      = vecs[i].m;
            if (!vecs[i].nrst) begin
                #1;
            end else begin
                @(posedge Clk);
                #1;
            end
            check($sformatf("vec%0d", i), Count, vecs[i].exp);
        end

        // Gray mode over two full cycles: each step must match the sequence and flip exactly one bit.
        @(negedge Clk);
        nReset = 1'b0;
        #1;
        check("gray_reset", Count, 3'd0);
        @(negedge Clk);
        nReset = 1'b1;
        M      = 1'b1;
        prev   = 3'd0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge Clk);
            #1;
            check($sformatf("gray_step%0d", k), Count, gray_seq[k % 8]);
            checks++;
            if ($countones(Count ^ prev) != 1) begin
                failures++;
                $display("FAIL gray_onebit%0d: changed bits=%0d expected 1", k, $countones(Count ^ prev));
            end
            prev = Count;
        end

        // M toggled between edges must not matter; only its value at the edge counts.
        @(negedge Clk);
        nReset = 1'b0;
        #1;
        nReset = 1'b1;
        M      = 1'b0;
        @(posedge Clk);
        #1;
        check("glitch_base", Count, 3'd1);
        #2 M = 1'b1;
        #2 M = 1'b0;
        @(posedge Clk);
        #1;
        check("glitch_binary", Count, 3'd2);
        @(posedge Clk);
        #1;
        check("glitch_binary2", Count, 3'd3);

        // Reset asserted shortly after an edge rather than on a negedge.
        #1 nReset = 1'b0;
        #1;
        check("async_midcycle", Count, 3'd0);
        @(posedge Clk);
        #1;
        check("held_in_reset", Count, 3'd0);
        @(negedge Clk);
        nReset = 1'b1;
        M      = 1'b1;
        exp_v  = gray_seq[1];
        @(posedge Clk);
        #1;
        check("release_gray", Count, exp_v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
